// File: rtl/window_max_peak_detector.sv
// Hysteresis peak detector fed by the sliding-window max tree.
// Emits one (peak, timestamp) event per excursion, with sample hold-off.
module window_max_peak_detector #(
    parameter int BW_DATA    = 8,
    parameter int BW_TS      = 16,
    parameter int BW_HOLDOFF = 8,
    parameter int BW_DROP    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_update,
    input  logic                  in_valid,
    input  logic [BW_DATA-1:0]    in_max,
    input  logic                  cfg_enable,
    input  logic [BW_DATA-1:0]    cfg_thr_hi,
    input  logic [BW_DATA-1:0]    cfg_thr_lo,
    input  logic [BW_HOLDOFF-1:0] cfg_holdoff,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [BW_DATA-1:0]    evt_peak,
    output logic [BW_TS-1:0]      evt_ts,
    output logic                  state_busy,
    output logic                  drop_sticky,
    output logic [BW_DROP-1:0]    drop_count
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        ABOVE,
        HOLDOFF
    } state_t;

    state_t                state, state_nxt;
    logic [BW_TS-1:0]      ts_cnt;
    logic [BW_TS-1:0]      peak_ts, peak_ts_nxt;
    logic [BW_DATA-1:0]    peak, peak_nxt;
    logic [BW_HOLDOFF-1:0] hold_cnt, hold_cnt_nxt;
    logic                  qual;
    logic                  emit;

    assign qual       = in_update & in_valid;
    assign state_busy = (state == ABOVE) || (state == HOLDOFF);

    always_comb begin
        state_nxt    = state;
        peak_nxt     = peak;
        peak_ts_nxt  = peak_ts;
        hold_cnt_nxt = hold_cnt;
        emit         = 1'b0;
        if (!cfg_enable) begin
            state_nxt    = IDLE;
            peak_nxt     = '0;
            hold_cnt_nxt = '0;
        end else begin
            unique case (state)
                IDLE: state_nxt = ARMED;
                ARMED: begin
                    if (qual && in_max >= cfg_thr_hi) begin
                        state_nxt   = ABOVE;
                        peak_nxt    = in_max;
                        peak_ts_nxt = ts_cnt;
                    end
                end
                ABOVE: begin
                    // lo <= hi <= peak, so a new peak and a fall never coincide
                    if (qual && in_max > peak) begin
                        peak_nxt    = in_max;
                        peak_ts_nxt = ts_cnt;
                    end else if (qual && in_max < cfg_thr_lo) begin
                        emit = 1'b1;
                        if (cfg_holdoff == '0) begin
                            state_nxt = ARMED;
                        end else begin
                            state_nxt    = HOLDOFF;
                            hold_cnt_nxt = cfg_holdoff;
                        end
                    end
                end
                HOLDOFF: begin
                    if (in_update) begin
                        hold_cnt_nxt = hold_cnt - BW_HOLDOFF'(1);
                        if (hold_cnt == BW_HOLDOFF'(1)) state_nxt = ARMED;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ts_cnt   <= '0;
            peak     <= '0;
            peak_ts  <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            peak     <= peak_nxt;
            peak_ts  <= peak_ts_nxt;
            hold_cnt <= hold_cnt_nxt;
            if (in_update) ts_cnt <= ts_cnt + BW_TS'(1);
        end
    end

    // Single-entry event register; a full, unconsumed slot drops new events
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_valid   <= 1'b0;
            evt_peak    <= '0;
            evt_ts      <= '0;
            drop_sticky <= 1'b0;
            drop_count  <= '0;
        end else if (emit) begin
            if (!evt_valid || evt_ready) begin
                evt_valid <= 1'b1;
                evt_peak  <= peak;
                evt_ts    <= peak_ts;
            end else begin
                drop_sticky <= 1'b1;
                if (drop_count != '1) drop_count <= drop_count + BW_DROP'(1);
            end
        end else if (evt_valid && evt_ready) begin
            evt_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_window_max_peak_detector.sv
// Bench: directed test-plan sequences plus random traffic vs an event model.
module tb_window_max_peak_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_update = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_max = '0;
    logic       cfg_enable = 1'b0;
    logic [7:0] cfg_thr_hi = 8'd100;
    logic [7:0] cfg_thr_lo = 8'd80;
    logic [7:0] cfg_holdoff = 8'd3;
    logic       evt_ready = 1'b1;

    logic        evt_valid, state_busy, drop_sticky;
    logic [7:0]  evt_peak, drop_count;
    logic [15:0] evt_ts;
    logic        w_valid, w_busy, w_sticky;
    logic [7:0]  w_peak, w_drop;
    logic [3:0]  w_ts;

    int n_chk = 0;
    int n_fail = 0;
    int nupd = 0;
    int t;

    always #5 clk = ~clk;

    window_max_peak_detector dut (
        .clk(clk), .rst(rst), .in_update(in_update), .in_valid(in_valid),
        .in_max(in_max), .cfg_enable(cfg_enable), .cfg_thr_hi(cfg_thr_hi),
        .cfg_thr_lo(cfg_thr_lo), .cfg_holdoff(cfg_holdoff),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_peak(evt_peak),
        .evt_ts(evt_ts), .state_busy(state_busy), .drop_sticky(drop_sticky),
        .drop_count(drop_count)
    );

    window_max_peak_detector #(.BW_TS(4)) dut_w (
        .clk(clk), .rst(rst), .in_update(in_update), .in_valid(in_valid),
        .in_max(in_max), .cfg_enable(cfg_enable), .cfg_thr_hi(cfg_thr_hi),
        .cfg_thr_lo(cfg_thr_lo), .cfg_holdoff(cfg_holdoff),
        .evt_valid(w_valid), .evt_ready(evt_ready), .evt_peak(w_peak),
        .evt_ts(w_ts), .state_busy(w_busy), .drop_sticky(w_sticky),
        .drop_count(w_drop)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Event-level reference: an excursion is tracked as mode/peak/ts ints
    localparam int M_IDLE = 0, M_ARMED = 1, M_ABOVE = 2, M_HOLD = 3;
    int m_ts, m_mode, m_peak, m_pts, m_hold;
    int m_ov, m_op, m_ots, m_sticky, m_drops;

    task automatic m_reset();
        m_ts = 0; m_mode = M_IDLE; m_peak = 0; m_pts = 0; m_hold = 0;
        m_ov = 0; m_op = 0; m_ots = 0; m_sticky = 0; m_drops = 0;
    endtask

    task automatic m_step();
        int  tsn = m_ts;
        bit  q = in_update && in_valid;
        bit  emit = 0;
        int  ep = 0, ets = 0;
        if (in_update) m_ts = (m_ts + 1) % 65536;
        if (!cfg_enable) begin
            m_mode = M_IDLE; m_peak = 0; m_hold = 0;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_ARMED;
        end else if (m_mode == M_ARMED) begin
            if (q && int'(in_max) >= int'(cfg_thr_hi)) begin
                m_mode = M_ABOVE; m_peak = in_max; m_pts = tsn;
            end
        end else if (m_mode == M_ABOVE) begin
            if (q && int'(in_max) > m_peak) begin
                m_peak = in_max; m_pts = tsn;
            end else if (q && int'(in_max) < int'(cfg_thr_lo)) begin
                emit = 1; ep = m_peak; ets = m_pts;
                m_hold = cfg_holdoff;
                m_mode = (m_hold == 0) ? M_ARMED : M_HOLD;
            end
        end else if (in_update) begin
            m_hold--;
            if (m_hold == 0) m_mode = M_ARMED;
        end
        if (emit) begin
            if (m_ov == 0 || evt_ready) begin
                m_ov = 1; m_op = ep; m_ots = ets;
            end else begin
                m_sticky = 1;
                if (m_drops < 255) m_drops++;
            end
        end else if (m_ov != 0 && evt_ready) begin
            m_ov = 0;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) m_reset();
        else m_step();
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("valid", evt_valid, m_ov);
            check("busy", state_busy, m_mode == M_ABOVE || m_mode == M_HOLD);
            check("sticky", drop_sticky, m_sticky);
            check("drops", drop_count, m_drops);
            check("w_valid", w_valid, m_ov);
            check("w_busy", w_busy, m_mode == M_ABOVE || m_mode == M_HOLD);
            check("w_sticky", w_sticky, m_sticky);
            check("w_drops", w_drop, m_drops);
            if (m_ov != 0) begin
                check("peak", evt_peak, m_op);
                check("ts", evt_ts, m_ots);
                check("w_peak", w_peak, m_op);
                check("w_ts", w_ts, m_ots % 16);
            end
        end
    end

    task automatic step(input logic upd, input logic vld, input logic [7:0] mx);
        in_update = upd;
        in_valid  = vld;
        in_max    = mx;
        @(negedge clk);
        in_update = 1'b0;
        if (upd) nupd++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_update = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        nupd = 0;
    endtask

    task automatic sample(input logic [7:0] mx);
        step(1'b1, 1'b1, mx);
    endtask

    initial begin
        do_reset();
        check("rst_valid", evt_valid, 0);
        check("rst_busy", state_busy, 0);
        check("rst_drops", drop_count, 0);
        cfg_enable = 1'b1;
        step(1'b0, 1'b0, 8'd0);

        // basic excursion with a tie on the peak
        sample(8'd50);
        sample(8'd100);
        t = nupd;
        sample(8'd120);
        sample(8'd120);
        sample(8'd90);
        check("basic_novalid", evt_valid, 0);
        sample(8'd79);
        check("basic_valid", evt_valid, 1);
        check("basic_peak", evt_peak, 120);
        check("basic_ts", evt_ts, t);

        // hold-off of 3 updates, then hold-off 0
        sample(8'd150);
        sample(8'd150);
        sample(8'd150);
        check("hold_armed", state_busy, 0);
        sample(8'd150);
        check("hold_above", state_busy, 1);
        cfg_holdoff = 8'd0;
        sample(8'd79);
        check("hold0_peak", evt_peak, 150);
        check("hold0_armed", state_busy, 0);

        // hysteresis: 80 is not below the falling threshold
        sample(8'd105);
        sample(8'd85);
        sample(8'd95);
        sample(8'd80);
        check("hyst_none", evt_valid, 0);
        sample(8'd79);
        check("hyst_valid", evt_valid, 1);
        check("hyst_peak", evt_peak, 105);
        step(1'b0, 1'b0, 8'd0);

        // backpressure and drop
        evt_ready = 1'b0;
        sample(8'd110);
        sample(8'd79);
        sample(8'd130);
        sample(8'd79);
        check("bp_peak", evt_peak, 110);
        check("bp_sticky", drop_sticky, 1);
        check("bp_count", drop_count, 1);
        evt_ready = 1'b1;
        step(1'b0, 1'b0, 8'd0);
        check("bp_consumed", evt_valid, 0);
        evt_ready = 1'b0;
        for (int i = 0; i < 260; i++) begin
            sample(8'd120);
            sample(8'd79);
        end
        check("sat_count", drop_count, 255);

        // enable and valid gating
        evt_ready = 1'b1;
        step(1'b0, 1'b0, 8'd0);
        sample(8'd115);
        check("en_above", state_busy, 1);
        cfg_enable = 1'b0;
        step(1'b0, 1'b0, 8'd0);
        check("en_idle", state_busy, 0);
        check("en_noevt", evt_valid, 0);
        cfg_enable = 1'b1;
        step(1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'd200);
        check("inval_ignored", state_busy, 0);
        t = nupd;
        sample(8'd120);
        sample(8'd79);
        check("inval_ts", evt_ts, t);

        // timestamp wrap on the 4-bit instance
        do_reset();
        cfg_enable = 1'b1;
        step(1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 8'd0);
        sample(8'd120);
        evt_ready = 1'b0;
        sample(8'd79);
        check("wrap_ts", evt_ts, 17);
        check("wrap_w_ts", w_ts, 1);
        sample(8'd110);
        sample(8'd79);
        check("pre_rst_drops", drop_count, 1);

        // asynchronous reset mid-cycle with a pending event
        #3 rst = 1'b1;
        #1;
        check("arst_valid", evt_valid, 0);
        check("arst_drops", drop_count, 0);
        check("arst_sticky", drop_sticky, 0);
        check("arst_w_valid", w_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        nupd = 0;
        evt_ready = 1'b1;
        step(1'b0, 1'b0, 8'd0);
        sample(8'd120);
        sample(8'd79);
        check("arst_ts", evt_ts, 0);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                cfg_thr_hi  = 8'($urandom_range(70, 130));
                cfg_thr_lo  = 8'($urandom_range(50, cfg_thr_hi));
                cfg_holdoff = 8'($urandom_range(0, 4));
            end
            cfg_enable = ($urandom_range(0, 99) != 0);
            evt_ready  = ($urandom_range(0, 3) != 0);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
                 8'($urandom_range(40, 160)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/window_max_peak_detector.md
Name: window_max_peak_detector

Overview:
- Downstream consumer of the 4-ary sliding-window maximum tree.
- Takes the tree's per-sample window maximum and valid flag, and applies hysteresis thresholds.
- Reports one peak event per excursion: peak value plus sample timestamp, on a valid/ready output.
- Enforces a programmable hold-off, counted in samples, between events.

Parameters:
- BW_DATA, 8, width of window-max value (matches tree data width).
- BW_TS, 16, width of sample timestamp counter.
- BW_HOLDOFF, 8, width of hold-off count.
- BW_DROP, 8, width of dropped-event counter.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- in_update  input  1  strobe: a new sample entered the window; in_valid/in_max are current this cycle.
- in_valid  input  1  tree output valid (window holds at least one loaded entry).
- in_max  input  BW_DATA  current window maximum, unsigned.
- cfg_enable  input  1  detector enable.
- cfg_thr_hi  input  BW_DATA  rising threshold, unsigned, inclusive.
- cfg_thr_lo  input  BW_DATA  falling threshold, unsigned, exclusive; software guarantees lo <= hi.
- cfg_holdoff  input  BW_HOLDOFF  samples to ignore after an event.
- evt_valid  output  1  event available.
- evt_ready  input  1  event consumed when evt_valid && evt_ready.
- evt_peak  output  BW_DATA  peak window max of the excursion.
- evt_ts  output  BW_TS  timestamp of the first sample that reached evt_peak.
- state_busy  output  1  FSM not in IDLE/ARMED.
- drop_sticky  output  1  an event was lost (output register still occupied).
- drop_count  output  BW_DROP  dropped events, saturating.

Behaviour:
- Reset: all outputs 0; FSM=IDLE; ts counter, peak, and hold-off counter = 0.
- Timestamp:
  - ts_cnt increments by 1 on every in_update, independent of cfg_enable; wraps 2^BW_TS-1 -> 0.
  - A sample's timestamp is the ts_cnt value before that cycle's increment.
- A sample is only "qualified" when in_update && in_valid; other cycles leave the FSM unchanged.
- IDLE:
  - cfg_enable=1 -> ARMED on the next cycle.
  - Samples are ignored in the cycle of the transition.
- ARMED: qualified sample with in_max >= cfg_thr_hi -> ABOVE; peak<=in_max, peak_ts<=sample ts.
- ABOVE:
  - Qualified sample with in_max > peak: peak<=in_max, peak_ts<=ts. Ties keep the earlier ts.
  - Qualified sample with in_max < cfg_thr_lo: emit event (peak, peak_ts).
    - cfg_holdoff=0 -> ARMED.
    - Otherwise -> HOLDOFF with hold_cnt<=cfg_holdoff.
  - Compare priority: "update peak" and "fall" are mutually exclusive because lo <= hi <= peak.
- HOLDOFF:
  - Each in_update decrements hold_cnt; qualification is not required.
  - When hold_cnt reaches 0 on a decrement -> ARMED.
  - Samples in HOLDOFF never start an excursion.
- Emit, latency 1:
  - evt_valid rises the cycle after the falling sample.
  - evt_peak/evt_ts are stable while evt_valid=1 && evt_ready=0.
- Single-entry output register:
  - Emit while the register is empty, or while it is being consumed in the same cycle (evt_valid && evt_ready): load the new event; evt_valid stays 1.
  - Emit while full and not consumed: new event discarded; drop_sticky<=1; drop_count increments, saturating at all-ones.
  - drop_sticky clears only on rst.
- cfg_enable=0 in any state:
  - Next cycle FSM=IDLE; peak and hold_cnt are cleared.
  - An in-progress excursion is abandoned, with no event.
  - A pending event in the output register remains until accepted.
- state_busy = (FSM==ABOVE || FSM==HOLDOFF).
- Reset mid-excursion or with a pending event: everything clears immediately and asynchronously; the event is lost without drop accounting.

Test Plan (BW_DATA=8, thr_hi=100, thr_lo=80, holdoff=3, evt_ready=1 unless stated):
- Basic excursion:
  - Stimulus: qualified samples max = 50, 100, 120, 120, 90, 79.
  - Required: one event, evt_peak=120, evt_ts = ts of the first 120 sample, evt_valid 1 cycle after the 79 sample.
  - Tie check: the second 120 must not update evt_ts.
- Hysteresis:
  - Stimulus: 105, 85, 95, 80, 79.
  - Required: no event until the 79 sample (80 is not < thr_lo); peak=105.
- Hold-off:
  - Stimulus: after an event, updates carrying 150, 150, 150, then 150.
  - Required: the first three are ignored (HOLDOFF -> ARMED after the 3rd update); the 4th enters ABOVE.
  - Repeat with holdoff=0: returns straight to ARMED.
- Backpressure/drop:
  - Stimulus: evt_ready=0; produce two excursions (peaks 110 then 130).
  - Required: evt_peak stays 110; drop_sticky=1; drop_count=1.
  - Raise evt_ready: 110 is consumed, evt_valid falls.
  - Drive 260 drops: drop_count saturates at 255.
- Enable and valid gating:
  - Stimulus: deassert cfg_enable while in ABOVE (peak 115).
  - Required: IDLE next cycle, no event, state_busy=0.
  - Stimulus: samples with in_valid=0 and max=200.
  - Required: ignored, but ts_cnt still increments.
- Reset and wrap:
  - Stimulus: BW_TS=4; 20 in_updates.
  - Required: ts wraps 15 -> 0.
  - Stimulus: assert rst asynchronously with evt_valid=1.
  - Required: evt_valid, drop_count, and ts go to 0 immediately, without a clock edge.
